// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states and fetch constants.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRun    = 2'd1,
        StHalted = 2'd2
    } state_t;

    localparam logic [7:0]  RESET_PC  = 8'h00;
    localparam logic [7:0]  PC_STEP   = 8'd4;
    localparam logic [31:0] HALT_WORD = 32'h0000_0000;

endpackage

// File: rtl/fetch_pc.sv
// Program counter register with hold / sequential-step / redirect next-PC selection.
module fetch_pc #(
    parameter logic [7:0] RESET_PC = 8'h00,
    parameter logic [7:0] PC_STEP  = 8'd4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       step,
    input  logic       redirect,
    input  logic [7:0] redirect_target,
    output logic [7:0] pc
);

    logic [7:0] pc_d;
    logic [7:0] pc_q;

    // Redirect wins over stepping; targets are forced to word alignment.
    always_comb begin
        pc_d = pc_q;
        if (redirect) begin
            pc_d = {redirect_target[7:2], 2'b00};
        end else if (step) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC sequencing, one-entry output register with backpressure,
// halt on zero word, and redirect with squash and misalignment flag.
module fetch_unit #(
    parameter logic [7:0] RESET_PC = fetch_unit_pkg::RESET_PC,
    parameter logic [7:0] PC_STEP  = fetch_unit_pkg::PC_STEP
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic [7:0]  imem_addr,
    input  logic [31:0] imem_rd,
    input  logic        redirect,
    input  logic [7:0]  redirect_target,
    output logic [31:0] instr,
    output logic [7:0]  instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        halted,
    output logic        align_err
);

    import fetch_unit_pkg::*;

    state_t      state_q, state_d;
    logic [7:0]  pc;
    logic [31:0] instr_q;
    logic [7:0]  instr_pc_q;
    logic        valid_q;
    logic        align_q;
    logic        slot_free;
    logic        zero_word;
    logic        fetch;
    logic        step;

    assign slot_free = !valid_q || instr_ready;
    assign zero_word = (imem_rd == HALT_WORD);
    // A fetch edge also covers IDLE with enable high, so the first fetch needs no warm-up cycle.
    assign fetch     = enable && (state_q != StHalted) && slot_free && !redirect;
    assign step      = fetch && !zero_word;

    fetch_pc #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_fetch_pc (
        .clk             (clk),
        .rst_n           (rst_n),
        .step            (step),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .pc              (pc)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (!redirect && enable) begin
                    state_d = (fetch && zero_word) ? StHalted : StRun;
                end
            end
            StRun: begin
                if (!redirect) begin
                    if (fetch && zero_word) begin
                        state_d = StHalted;
                    end else if (!enable) begin
                        state_d = StIdle;
                    end
                end
            end
            StHalted: begin
                if (redirect) begin
                    state_d = StRun;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            align_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            align_q <= redirect && (redirect_target[1:0] != 2'b00);
            if (redirect) begin
                valid_q <= 1'b0;
            end else if (step) begin
                instr_q    <= imem_rd;
                instr_pc_q <= pc;
                valid_q    <= 1'b1;
            end else if (slot_free) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign imem_addr   = pc;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = valid_q;
    assign halted      = (state_q == StHalted);
    assign align_err   = align_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random traffic against a behavioural model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rd;
    logic        redirect;
    logic [7:0]  redirect_target;
    logic [31:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        halted;
    logic        align_err;

    logic [31:0] mem [64];

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: 0 idle, 1 running, 2 halted
    int          m_st;
    logic [7:0]  m_pc;
    logic [31:0] m_instr;
    logic [7:0]  m_ipc;
    logic        m_valid;
    logic        m_align;

    always #5 clk = ~clk;

    assign imem_rd = mem[imem_addr[7:2]];

    fetch_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable          (enable),
        .imem_addr       (imem_addr),
        .imem_rd         (imem_rd),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .halted          (halted),
        .align_err       (align_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_st = 0; m_pc = 8'h00; m_instr = '0; m_ipc = '0; m_valid = 0; m_align = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".instr"},     instr,       m_instr);
        check({tag, ".instr_pc"},  {24'h0, instr_pc},  {24'h0, m_ipc});
        check({tag, ".valid"},     {31'h0, instr_valid}, {31'h0, m_valid});
        check({tag, ".addr"},      {24'h0, imem_addr}, {24'h0, m_pc});
        check({tag, ".halted"},    {31'h0, halted},    {31'h0, 1'(m_st == 2)});
        check({tag, ".align_err"}, {31'h0, align_err}, {31'h0, m_align});
    endtask

    // One clock: what the fetch stage should do, stated from the rules of the block.
    task automatic step(input logic en, input logic rdy, input logic rd, input logic [7:0] tgt);
        logic        free;
        logic [31:0] w;
        enable = en; instr_ready = rdy; redirect = rd; redirect_target = tgt;
        free = !m_valid || rdy;
        w    = mem[m_pc[7:2]];
        m_align = rd && (tgt % 4 != 0);
        if (rd) begin
            m_pc    = tgt - (tgt % 4);
            m_valid = 0;
            if (m_st == 2) m_st = 1;
        end else if (m_st != 2 && en && free) begin
            if (w == 0) begin
                m_valid = 0;
                m_st    = 2;
            end else begin
                m_instr = w;
                m_ipc   = m_pc;
                m_valid = 1;
                m_pc    = m_pc + 8'd4;
                m_st    = 1;
            end
        end else begin
            if (free) m_valid = 0;
            if (m_st == 1 && !en) m_st = 0;
            else if (m_st == 0 && en) m_st = 1;
        end
        @(posedge clk);
        #1;
        check_all("step");
    endtask

    initial begin
        rst_n = 0; enable = 0; instr_ready = 0; redirect = 0; redirect_target = '0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
        mem[0] = 32'h0010_0193;
        mem[1] = 32'h0ff0_0083;
        mem[2] = 32'h0011_f133;
        mem[6] = 32'h0000_0000;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1;

        // Sequential fetch from reset
        step(1, 1, 0, 8'h00);
        check("seq0.pc", {24'h0, instr_pc}, 32'h00);
        check("seq0.instr", instr, 32'h0010_0193);
        step(1, 1, 0, 8'h00);
        check("seq1.pc", {24'h0, instr_pc}, 32'h04);

        // Three-cycle stall at 04
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 8'h00);
            check("stall.instr", instr, 32'h0ff0_0083);
            check("stall.addr", {24'h0, imem_addr}, 32'h08);
        end
        step(1, 1, 0, 8'h00);
        check("release.pc", {24'h0, instr_pc}, 32'h08);
        check("release.instr", instr, 32'h0011_f133);

        // Advance to 14, stall, redirect to 00 squashes
        for (int i = 0; i < 3; i++) step(1, 1, 0, 8'h00);
        check("at14.pc", {24'h0, instr_pc}, 32'h14);
        step(1, 0, 0, 8'h00);
        step(1, 0, 1, 8'h00);
        check("squash.valid", {31'h0, instr_valid}, 32'h0);
        step(1, 1, 0, 8'h00);
        check("resume.pc", {24'h0, instr_pc}, 32'h00);
        check("resume.instr", instr, 32'h0010_0193);

        // Run into the zero word at 18
        for (int i = 0; i < 6; i++) step(1, 1, 0, 8'h00);
        check("halt.halted", {31'h0, halted}, 32'h1);
        check("halt.valid", {31'h0, instr_valid}, 32'h0);
        step(1, 1, 0, 8'h00);
        check("halt.addr", {24'h0, imem_addr}, 32'h18);
        step(1, 1, 1, 8'h00);
        check("unhalt", {31'h0, halted}, 32'h0);
        step(1, 1, 0, 8'h00);
        check("unhalt.pc", {24'h0, instr_pc}, 32'h00);

        // Misaligned redirect
        step(1, 1, 1, 8'h0E);
        check("align.pulse", {31'h0, align_err}, 32'h1);
        step(1, 1, 0, 8'h00);
        check("align.clear", {31'h0, align_err}, 32'h0);
        check("align.pc", {24'h0, instr_pc}, 32'h0C);

        // Wrap at FC, then async reset while stalled
        step(1, 1, 1, 8'hFC);
        step(1, 1, 0, 8'h00);
        check("wrap.pc", {24'h0, instr_pc}, 32'hFC);
        check("wrap.addr", {24'h0, imem_addr}, 32'h00);
        step(1, 0, 0, 8'h00);
        #2;
        rst_n = 0;
        #1;
        model_reset();
        check_all("async_reset");
        @(negedge clk);
        check_all("reset_held");
        rst_n = 1;

        // Random traffic
        for (int i = 0; i < 64; i++)
            mem[i] = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom() | 32'h1;
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 9) < 7),
                 1'($urandom_range(0, 11) == 0), 8'($urandom_range(0, 255)));
        end
        redirect = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-002 Parameter RESET_PC, default 8'h00, is the first fetch address after reset.
REQ-003 Parameter PC_STEP, default 8'd4, is the sequential address increment.
REQ-004 Port clk, input, 1 bit: rising-edge clock.
REQ-005 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 Port enable, input, 1 bit: fetch permitted while high.
REQ-007 Port imem_addr, output, 8 bits: combinational copy of the PC, driven to instruction memory address A.
REQ-008 Port imem_rd, input, 32 bits: combinational instruction word returned for imem_addr.
REQ-009 Port redirect, input, 1 bit: branch/jump taken; single-cycle pulse.
REQ-010 Port redirect_target, input, 8 bits: new fetch address.
REQ-011 Port instr, output, 32 bits: registered instruction to decode.
REQ-012 Port instr_pc, output, 8 bits: address instr was fetched from.
REQ-013 Port instr_valid, output, 1 bit: instr/instr_pc hold a live instruction.
REQ-014 Port instr_ready, input, 1 bit: decode accepts instr this cycle.
REQ-015 Port halted, output, 1 bit: high while in HALTED.
REQ-016 Port align_err, output, 1 bit: one-cycle pulse on a misaligned redirect.

Function
REQ-017 States: IDLE, RUN, HALTED.
REQ-018 Transitions: IDLE->RUN when enable=1; RUN->IDLE when enable=0; RUN->HALTED on capturing imem_rd==32'h0; HALTED->RUN on redirect. All other cases hold state.
REQ-019 The output slot is free when instr_valid==0 or instr_ready==1.
REQ-020 In RUN with no redirect and a free slot: instr<=imem_rd, instr_pc<=PC, instr_valid<=1, PC<=PC+PC_STEP.
REQ-021 Fetch latency: the word at PC appears on instr one cycle after the fetch edge.
REQ-022 If the slot is not free: PC, instr, instr_pc and instr_valid hold unchanged.
REQ-023 Free slot with no new capture (IDLE, HALTED, or zero-word capture): instr_valid<=0.
REQ-024 A zero word is never presented as valid: instr_valid<=0, PC is not advanced, state goes to HALTED.
REQ-025 Redirect has priority over every other event in every state: PC<={redirect_target[7:2],2'b00}; instr_valid<=0 (squash, even while stalled); no capture that cycle; HALTED->RUN.
REQ-026 Redirect in IDLE updates PC only; the state stays IDLE.
REQ-027 align_err<=1 for one cycle when redirect is high and redirect_target[1:0]!=0; otherwise 0.
REQ-028 PC arithmetic is 8-bit modulo: 8'hFC+4 wraps to 8'h00 without a flag.
REQ-029 enable falling while a word is held stalled: the word stays valid until accepted; no new fetch.

Reset
REQ-030 While rst_n=0: PC=RESET_PC, state=IDLE, instr=0, instr_pc=0, instr_valid=0, halted=0, align_err=0.
REQ-031 Reset asserted mid-operation SHALL discard the in-flight instruction immediately, without waiting for a clock edge.
REQ-032 The first fetch after reset release SHALL occur on the first edge where enable=1.

Structure
REQ-033 The shared core package SHALL hold the state enum, RESET_PC, PC_STEP and HALT_WORD (32'h0).
REQ-034 One sub-module, fetch_pc, SHALL contain the PC register and the next-PC mux (hold/step/redirect); the FSM and output register stay in fetch_unit.

Verification
REQ-035 Reset, enable=1, instr_ready=1, memory holding 00100193, 0ff00083, 0011f133 at 00/04/08 -> instr_pc 00,04,08 on consecutive cycles with matching instr and instr_valid=1.
REQ-036 Hold instr_ready=0 for 3 cycles while instr_pc=04 -> instr=0ff00083 stable, imem_addr stays 08; release -> 08 follows next cycle.
REQ-037 Redirect to 8'h00 while instr_pc=14 (stalled) -> instr_valid=0 next cycle; then instr_pc=00, instr=00100193.
REQ-038 Fetch reaching 8'h18 (word 0) -> instr_valid=0, halted=1, imem_addr stays 18; redirect to 00 -> halted=0, fetch resumes at 00.
REQ-039 Redirect to 8'h0E -> align_err pulses 1 cycle; next instr_pc=0C.
REQ-040 PC reaching 8'hFC with nonzero word -> next fetch address 00; rst_n low mid-stall -> all outputs reach reset values before the next edge.
